// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, frame width and counter sizing.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Width of a counter that must reach clks-1; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous level input; resets to 1 (idle line / released button).
// Latency: STAGES clocks; no backpressure (free-running sampler).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/bluetooth.sv
// 8N1 UART receiver for the Bluetooth serial link; data/data_valid land SYNC_STAGES+1 clocks after mid stop bit.
// No backpressure: each good frame overwrites data and pulses data_valid once; a low stop bit pulses frame_err.
module bluetooth
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 get,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    state_t               r_state,      w_state_nx;
    logic [CNT_W-1:0]     r_clk_cnt,    w_clk_cnt_nx;
    logic [IDX_W-1:0]     r_bit_idx,    w_bit_idx_nx;
    logic [DATA_BITS-1:0] r_shift,      w_shift_nx;
    logic [DATA_BITS-1:0] r_data,       w_data_nx;
    logic                 r_data_valid, w_data_valid_nx;
    logic                 r_frame_err,  w_frame_err_nx;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (get),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_clk_cnt    <= w_clk_cnt_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_shift      <= w_shift_nx;
            r_data       <= w_data_nx;
            r_data_valid <= w_data_valid_nx;
            r_frame_err  <= w_frame_err_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_clk_cnt_nx    = r_clk_cnt;
        w_bit_idx_nx    = r_bit_idx;
        w_shift_nx      = r_shift;
        w_data_nx       = r_data;
        w_data_valid_nx = 1'b0;
        w_frame_err_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_clk_cnt_nx = '0;
                    w_state_nx   = START;
                end
            end
            // A line that is high again at mid start bit was only a glitch.
            START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt_nx = '0;
                    if (!w_rx_s) begin
                        w_bit_idx_nx = '0;
                        w_state_nx   = DATA;
                    end else begin
                        w_state_nx   = IDLE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_clk_cnt == CNT_FULL) begin
                    w_clk_cnt_nx          = '0;
                    w_shift_nx[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nx = STOP;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
                end
            end
            // Leaving at mid stop bit lets an immediately following start bit be caught.
            STOP: begin
                if (r_clk_cnt == CNT_FULL) begin
                    w_clk_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_data_nx       = r_shift;
                        w_data_valid_nx = 1'b1;
                        w_state_nx      = IDLE;
                    end else begin
                        w_frame_err_nx  = 1'b1;
                        w_state_nx      = WAIT_IDLE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_bluetooth.sv
// Bench for the Bluetooth UART receiver: serial frames driven bit by bit, checked against a byte-level model.
module tb_bluetooth;

    localparam int CPB = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       get = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model: what the receiver should have reported, tracked per frame sent.
    logic [7:0] model_data = 8'h00;
    int         exp_valid  = 0;
    int         exp_ferr   = 0;

    // Observations collected from the outputs.
    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    int         dbl_cnt  = 0;
    logic       prev_v   = 1'b0;
    logic       prev_f   = 1'b0;

    bluetooth #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .get        (get),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #1 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) got_q.push_back(data);
        if (frame_err) ferr_cnt++;
        if ((data_valid && prev_v) || (frame_err && prev_f)) dbl_cnt++;
        prev_v = data_valid;
        prev_f = frame_err;
    end

    task automatic tx(input logic [7:0] b, input logic stop);
        get = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            get = b[i];
            repeat (CPB) @(negedge clk);
        end
        get = stop;
        repeat (CPB) @(negedge clk);
        if (stop) begin
            model_data = b;
            exp_valid++;
        end else begin
            exp_ferr++;
        end
    endtask

    // Bounded wait for outstanding pulses; an expired bound shows up in the checks that follow.
    task automatic settle();
        for (int i = 0; i < 3 * CPB && (got_q.size() < exp_valid || ferr_cnt < exp_ferr); i++)
            @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            get = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (data !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: data=%h valid=%b ferr=%b, required 00/0/0",
                         i, data, data_valid, frame_err);
            end
        end
        get = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || data !== 8'h00 || ferr_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle: valids=%0d data=%h ferrs=%0d, required 0/00/0",
                     got_q.size(), data, ferr_cnt);
        end
    endtask

    task automatic test_single();
        tx(8'h41, 1'b1);
        settle();
        checks++;
        if (got_q.size() != 1 || data !== 8'h41) begin
            errors++;
            $display("FAIL single_char: valids=%0d data=%h, required 1/41", got_q.size(), data);
        end
        checks++;
        if (ferr_cnt != 0) begin
            errors++;
            $display("FAIL single_ferr: ferrs=%0d, required 0", ferr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = got_q.size();
        tx(8'h57, 1'b1);
        tx(8'h53, 1'b1);
        settle();
        checks++;
        if (got_q.size() != base + 2) begin
            errors++;
            $display("FAIL b2b_count: valids=%0d, required %0d", got_q.size() - base, 2);
        end else begin
            checks++;
            if (got_q[base] !== 8'h57 || got_q[base+1] !== 8'h53) begin
                errors++;
                $display("FAIL b2b_bytes: got %h,%h required 57,53", got_q[base], got_q[base+1]);
            end
        end
        checks++;
        if (data !== 8'h53) begin
            errors++;
            $display("FAIL b2b_hold: data=%h required 53", data);
        end
    endtask

    task automatic test_glitch();
        int         v0;
        logic [7:0] d0;
        logic [7:0] b;
        v0 = got_q.size();
        d0 = model_data;
        get = 1'b0;
        repeat (4) @(negedge clk);
        get = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (got_q.size() != v0 || data !== d0 || ferr_cnt != exp_ferr) begin
            errors++;
            $display("FAIL glitch: valids=%0d data=%h ferrs=%0d, required %0d/%h/%0d",
                     got_q.size(), data, ferr_cnt, v0, d0, exp_ferr);
        end
        b = 8'($urandom);
        tx(b, 1'b1);
        settle();
        checks++;
        if (got_q.size() != exp_valid || data !== b) begin
            errors++;
            $display("FAIL after_glitch: valids=%0d data=%h, required %0d/%h",
                     got_q.size(), data, exp_valid, b);
        end
    endtask

    task automatic test_frame_err();
        int         v0;
        int         f0;
        logic [7:0] d0;
        v0 = got_q.size();
        f0 = ferr_cnt;
        d0 = model_data;
        tx(8'h41, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        get = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (ferr_cnt != f0 + 1) begin
            errors++;
            $display("FAIL ferr_pulse: pulses=%0d required 1", ferr_cnt - f0);
        end
        checks++;
        if (got_q.size() != v0 || data !== d0) begin
            errors++;
            $display("FAIL ferr_hold: valids=%0d data=%h, required %0d/%h", got_q.size(), data, v0, d0);
        end
        tx(8'h44, 1'b1);
        settle();
        checks++;
        if (got_q.size() != v0 + 1 || data !== 8'h44) begin
            errors++;
            $display("FAIL after_ferr: valids=%0d data=%h, required %0d/44", got_q.size(), data, v0 + 1);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        get = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            get = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: data=%h valid=%b ferr=%b, required 00/0/0",
                     data, data_valid, frame_err);
        end
        get = 1'b1;
        rst = 1'b1;
        model_data = 8'h00;
        v0 = got_q.size();
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (got_q.size() != v0 || data !== 8'h00) begin
            errors++;
            $display("FAIL midframe_spurious: valids=%0d data=%h, required %0d/00", got_q.size(), data, v0);
        end
        tx(8'h61, 1'b1);
        settle();
        checks++;
        if (got_q.size() != v0 + 1 || data !== 8'h61) begin
            errors++;
            $display("FAIL after_midframe: valids=%0d data=%h, required %0d/61", got_q.size(), data, v0 + 1);
        end
        exp_valid = got_q.size();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        int         gap;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 2 * CPB) : $urandom_range(4, 2 * CPB);
            tx(b, stop);
            get = 1'b1;
            repeat (gap) @(negedge clk);
            settle();
            checks++;
            if (got_q.size() != exp_valid || data !== model_data || ferr_cnt != exp_ferr) begin
                errors++;
                $display("FAIL random n=%0d byte=%h stop=%b: valids=%0d data=%h ferrs=%0d, required %0d/%h/%0d",
                         n, b, stop, got_q.size(), data, ferr_cnt, exp_valid, model_data, exp_ferr);
            end
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (dbl_cnt != 0) begin
            errors++;
            $display("FAIL pulse_width: multi-cycle pulses=%0d required 0", dbl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
        test_pulse_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
